// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit scheduler.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } tx_sched_state_t;

  // Index of the requester 'off' places after 'base' in a ring of 'n'.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a combinational head. A write while full is honoured only
// when a read retires the head in the same cycle.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [BYTE_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [BYTE_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_wr_s;
  logic              do_rd_s;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == CW'(0));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);

  // Next pointer and occupancy values for the coming edge.
  always_comb begin
    wr_ptr_d = do_wr_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NREQ byte streams: round-robin
// arbitration with message locking feeds a byte FIFO, and a sequencer issues
// one frame at a time with an idle gap after each tx_done.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_sig,
  output logic [BYTE_W-1:0]        tx_data,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int GW    = $clog2(NREQ);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  // Arbiter state
  logic          locked_q, locked_d;
  logic [GW-1:0] lock_id_q, lock_id_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] grant_s;
  logic          grant_vld_s;
  logic          hs_s;
  logic [BYTE_W-1:0] wr_data_s;

  // Sequencer state
  tx_sched_state_t   state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_sig_q;

  // FIFO interface
  logic              rd_en_s;
  logic [BYTE_W-1:0] rd_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CW-1:0]     fifo_count_s;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hs_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_en_s),
    .rd_data (rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Grant selection: the locked owner, else the first valid requester at or after rr_q.
  always_comb begin
    grant_s     = rr_q;
    grant_vld_s = 1'b0;
    if (locked_q) begin
      grant_s     = lock_id_q;
      grant_vld_s = 1'b1;
    end else begin
      // Walk from the farthest candidate back so the nearest valid one wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
        grant_s     = req_valid[rr_index(int'(rr_q), i, NREQ)]
                      ? GW'(rr_index(int'(rr_q), i, NREQ)) : grant_s;
        grant_vld_s = grant_vld_s | req_valid[rr_index(int'(rr_q), i, NREQ)];
      end
    end
  end

  // Ready goes only to the granted requester and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    if (grant_vld_s && !fifo_full_s && !rst) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Byte lane of the granted requester.
  always_comb begin
    wr_data_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      wr_data_s = (GW'(k) == grant_s) ? req_data[k*BYTE_W +: BYTE_W] : wr_data_s;
    end
  end

  assign hs_s = grant_vld_s & ~fifo_full_s & req_valid[grant_s] & ~rst;

  // Lock and round-robin updates on each accepted byte.
  always_comb begin
    locked_d   = locked_q;
    lock_id_d  = lock_id_q;
    rr_d       = rr_q;
    grant_id_d = grant_id_q;
    if (hs_s) begin
      grant_id_d = grant_s;
      if (req_last[grant_s]) begin
        locked_d = 1'b0;
        rr_d     = (grant_s == GW'(NREQ - 1)) ? GW'(0) : grant_s + GW'(1);
      end else begin
        locked_d  = 1'b1;
        lock_id_d = grant_s;
      end
    end else begin
      grant_id_d = grant_id_q;
    end
  end

  // Arbiter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q   <= 1'b0;
      lock_id_q  <= '0;
      rr_q       <= '0;
      grant_id_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_id_q  <= lock_id_d;
      rr_q       <= rr_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Sequencer next state: pop, pulse start, wait for done, then idle gap.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    rd_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          rd_en_s   = 1'b1;
          tx_data_d = rd_data_s;
          state_d   = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_W'(GAP_CYCLES);
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; tx_sig is registered alongside entry into START.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      tx_data_q <= '0;
      tx_sig_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_sig_q  <= (state_d == S_START);
    end
  end

  assign tx_sig   = tx_sig_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != S_IDLE) || (fifo_count_s != CW'(0));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler. A behavioural model tracks the byte
// queue, arbitration rules and frame timing arithmetic, and every output is
// compared to it each cycle.
module tb_uart_tx_scheduler;

  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int GAP   = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [8*NREQ-1:0]    req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_sig;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic [$clog2(NREQ)-1:0] grant_id;

  uart_tx_scheduler #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_sig    (tx_sig),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus sources: {last, byte} per requester
  logic [8:0] src [NREQ][$];
  int         vprob;

  // Reference model state
  int         cyc;
  logic [7:0] q_data[$];
  int         q_w[$];
  bit         inflight;
  int         last_done;
  int         done_at;
  int         lat_lo, lat_hi;
  int         budget;
  int         lock;
  int         rr;
  int         last_grant;
  logic [7:0] cur_byte;
  bit         spurious;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    q_data.delete();
    q_w.delete();
    for (int k = 0; k < NREQ; k++) src[k].delete();
    inflight   = 1'b0;
    last_done  = -1000;
    done_at    = 0;
    lock       = -1;
    rr         = 0;
    last_grant = 0;
    cur_byte   = 8'h00;
    budget     = -1;
    cyc        = 0;
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      if (src[k].size() > 0) begin
        req_valid[k]         = ($urandom_range(99) < vprob);
        req_data[8*k +: 8]   = src[k][0][7:0];
        req_last[k]          = src[k][0][8];
      end else begin
        req_valid[k]         = 1'b0;
        req_data[8*k +: 8]   = 8'h00;
        req_last[k]          = 1'b0;
      end
    end
    tx_done  = spurious || (inflight && (cyc >= done_at) && (budget != 0));
    spurious = 1'b0;
  endtask

  task automatic check_and_update();
    bit         exp_sig;
    bit         gv;
    int         g;
    logic [NREQ-1:0] exp_rdy;
    logic [8:0] b;
    exp_sig = 1'b0;
    if (!inflight && q_data.size() > 0)
      exp_sig = (cyc == imax(q_w[0] + 2, last_done + GAP + 2));
    check_value("tx_sig", tx_sig, exp_sig);
    if (exp_sig) begin
      cur_byte = q_data.pop_front();
      void'(q_w.pop_front());
      inflight = 1'b1;
      done_at  = cyc + $urandom_range(lat_hi, lat_lo);
    end
    check_value("tx_data", tx_data, cur_byte);
    check_value("busy", busy, (q_data.size() > 0) || inflight || (cyc <= last_done + GAP));
    gv = 1'b0;
    g  = 0;
    if (lock >= 0) begin
      g  = lock;
      gv = 1'b1;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gv && req_valid[(rr + i) % NREQ]) begin
          g  = (rr + i) % NREQ;
          gv = 1'b1;
        end
      end
    end
    exp_rdy = '0;
    if (gv && q_data.size() < DEPTH) exp_rdy[g] = 1'b1;
    check_value("req_ready", req_ready, exp_rdy);
    check_value("grant_id", grant_id, last_grant);
    if (exp_rdy[g] && req_valid[g]) begin
      b = src[g].pop_front();
      q_data.push_back(b[7:0]);
      q_w.push_back(cyc);
      last_grant = g;
      if (b[8]) begin
        lock = -1;
        rr   = (g + 1) % NREQ;
      end else begin
        lock = g;
      end
    end
    if (tx_done && inflight) begin
      last_done = cyc;
      inflight  = 1'b0;
      if (budget > 0) budget--;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_inputs();
      @(negedge clk);
      check_and_update();
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(input bit spur);
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_value("rst_tx_sig", tx_sig, 1'b0);
    check_value("rst_tx_data", tx_data, 8'h00);
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_grant", grant_id, 0);
    check_value("rst_ready", req_ready, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    spurious = spur;
  endtask

  initial begin
    spurious = 1'b0;
    vprob    = 100;
    lat_lo   = 2;
    lat_hi   = 2;
    model_reset();

    // 1: single byte, transmitter answers 100 cycles after the start pulse
    do_reset(1'b0);
    lat_lo = 100; lat_hi = 100;
    src[0].push_back({1'b1, 8'hA5});
    run(140);

    // 2: locked message ABC from req0 while req1 holds a single byte
    do_reset(1'b0);
    lat_lo = 3; lat_hi = 3;
    src[0].push_back({1'b0, 8'h41});
    src[0].push_back({1'b0, 8'h42});
    src[0].push_back({1'b1, 8'h43});
    src[1].push_back({1'b1, 8'h31});
    run(120);

    // 3: round-robin with continuous single-byte messages
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      src[0].push_back({1'b1, 8'(8'h10 + i)});
      src[1].push_back({1'b1, 8'(8'h20 + i)});
    end
    run(400);

    // 4/5: fill the FIFO with the transmitter stalled, release one frame, then drain
    do_reset(1'b0);
    lat_lo = 2; lat_hi = 2;
    budget = 0;
    for (int i = 0; i < 12; i++) src[0].push_back({1'b1, 8'(8'h60 + i)});
    run(40);
    budget = 1;
    run(40);
    budget = -1;
    run(300);

    // Random messages, gated valids, random transmitter latency
    do_reset(1'b0);
    vprob  = 70;
    lat_lo = 1; lat_hi = 6;
    for (int m = 0; m < 14; m++) begin
      int r, len;
      r   = $urandom_range(NREQ - 1);
      len = $urandom_range(3, 1);
      for (int j = 0; j < len; j++)
        src[r].push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
    end
    run(900);

    // 6: reset while waiting for tx_done, then a spurious tx_done afterwards
    do_reset(1'b0);
    vprob  = 100;
    budget = 0;
    src[0].push_back({1'b1, 8'h77});
    src[0].push_back({1'b1, 8'h78});
    run(10);
    do_reset(1'b1);
    run(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
